// File: rtl/ret_stack_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | ret_stack_ctrl_pkg : shared widths and op decode for the return stack    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package ret_stack_ctrl_pkg;

  localparam int RS_ADDR_W = 8;
  localparam int RS_DEPTH  = 16;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_SWAP = 2'd3
  } stk_op_e;

  // A flushed slot (valid_in low) never touches the stack.
  function automatic stk_op_e decode_op(input logic valid, input logic call, input logic ret);
    stk_op_e op;
    op = OP_NONE;
    if (valid) begin
      unique case ({call, ret})
        2'b10:   op = OP_PUSH;
        2'b01:   op = OP_POP;
        2'b11:   op = OP_SWAP;
        default: op = OP_NONE;
      endcase
    end
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ret_stack_mem.sv
// +--------------------------------------------------------------------------+
// | ret_stack_mem : DEPTH x ADDR_W register array, 1 sync write, 1 async rd  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ret_stack_mem #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [ADDR_W-1:0] rdata_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/ret_stack_ctrl.sv
// +--------------------------------------------------------------------------+
// | ret_stack_ctrl : call/return address stack controller with wrap + flags  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ret_stack_ctrl
  import ret_stack_ctrl_pkg::*;
#(
  parameter int ADDR_W = RS_ADDR_W,
  parameter int DEPTH  = RS_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] pcp1,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              empty,
  output logic              full,
  output logic [PTR_W:0]    count,
  output logic              ovf_err,
  output logic              unf_err,
  output logic              ret_taken
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]  top_q, top_d, top_m1, waddr;
  logic [PTR_W:0]    count_q, count_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, ret_taken_q;
  logic              ovf_set, unf_set, we;
  logic [ADDR_W-1:0] rdata;
  stk_op_e           op;

  assign op     = decode_op(valid_in, call, ret);
  assign top_m1 = top_q - PTR_W'(1);
  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_FULL);

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    we      = 1'b0;
    waddr   = top_q;
    unique case (op)
      OP_PUSH: begin
        // When full, the slot at top is the oldest entry, so it is overwritten.
        we    = 1'b1;
        top_d = top_q + PTR_W'(1);
        if (full) ovf_set = 1'b1;
        else      count_d = count_q + 1'b1;
      end
      OP_POP: begin
        if (empty) begin
          unf_set = 1'b1;
        end else begin
          top_d   = top_m1;
          count_d = count_q - 1'b1;
        end
      end
      OP_SWAP: begin
        we = 1'b1;
        if (empty) begin
          top_d   = top_q + PTR_W'(1);
          count_d = count_q + 1'b1;
          unf_set = 1'b1;
        end else begin
          waddr = top_m1;
        end
      end
      default: ;
    endcase
    ovf_d = ovf_set | (ovf_q & ~err_clr);
    unf_d = unf_set | (unf_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      ret_taken_q <= 1'b0;
    end else begin
      top_q       <= top_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      ret_taken_q <= (op == OP_POP) || (op == OP_SWAP);
    end
  end

  ret_stack_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (we & ~rst),
    .waddr_i (waddr),
    .wdata_i (pcp1),
    .raddr_i (top_m1),
    .rdata_o (rdata)
  );

  assign ret_addr  = empty ? '0 : rdata;
  assign count     = count_q;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;
  assign ret_taken = ret_taken_q;

endmodule

`default_nettype wire

// File: tb/tb_ret_stack_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_ret_stack_ctrl : vector table, corner sequences and random vs queue   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ret_stack_ctrl;

  logic       clk = 1'b0;
  logic       rst, valid_in, call, ret, err_clr;
  logic [7:0] pcp1;
  logic [7:0] ret_addr;
  logic       empty, full, ovf_err, unf_err, ret_taken;
  logic [4:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the live stack as a queue, newest at the back.
  int unsigned q[$];
  bit m_ovf, m_unf, m_rt;

  typedef struct {
    bit       v, c, r, clr;
    bit [7:0] p;
    bit [7:0] exp_ra;
    int       exp_cnt;
  } vec_t;
  vec_t tbl[8];

  ret_stack_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .call      (call),
    .ret       (ret),
    .pcp1      (pcp1),
    .err_clr   (err_clr),
    .ret_addr  (ret_addr),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .ovf_err   (ovf_err),
    .unf_err   (unf_err),
    .ret_taken (ret_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit so, su;
    so = 0; su = 0;
    if (rst) begin
      q.delete(); m_ovf = 0; m_unf = 0; m_rt = 0;
      return;
    end
    m_rt = 0;
    if (valid_in && call && !ret) begin
      if (q.size() == 16) begin void'(q.pop_front()); so = 1; end
      q.push_back(pcp1);
    end else if (valid_in && ret && !call) begin
      m_rt = 1;
      if (q.size() == 0) su = 1;
      else void'(q.pop_back());
    end else if (valid_in && ret && call) begin
      m_rt = 1;
      if (q.size() == 0) begin q.push_back(pcp1); su = 1; end
      else q[q.size()-1] = pcp1;
    end
    m_ovf = so | (m_ovf & ~err_clr);
    m_unf = su | (m_unf & ~err_clr);
  endfunction

  task automatic check_all();
    int exp_ra;
    exp_ra = (q.size() == 0) ? 0 : int'(q[q.size()-1]);
    chk("ret_addr",  int'(ret_addr),  exp_ra);
    chk("count",     int'(count),     q.size());
    chk("empty",     int'(empty),     int'(q.size() == 0));
    chk("full",      int'(full),      int'(q.size() == 16));
    chk("ovf_err",   int'(ovf_err),   int'(m_ovf));
    chk("unf_err",   int'(unf_err),   int'(m_unf));
    chk("ret_taken", int'(ret_taken), int'(m_rt));
  endtask

  task automatic drive(input bit v, input bit c, input bit r, input bit [7:0] p, input bit clr);
    valid_in = v; call = c; ret = r; pcp1 = p; err_clr = clr;
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic tick();
    #2;
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 8'h00, 0);
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{v:1, c:1, r:0, clr:0, p:8'h10, exp_ra:8'h00, exp_cnt:0};
    tbl[1] = '{v:1, c:1, r:0, clr:0, p:8'h20, exp_ra:8'h10, exp_cnt:1};
    tbl[2] = '{v:1, c:1, r:0, clr:0, p:8'h30, exp_ra:8'h20, exp_cnt:2};
    tbl[3] = '{v:1, c:0, r:1, clr:0, p:8'h00, exp_ra:8'h30, exp_cnt:3};
    tbl[4] = '{v:1, c:0, r:1, clr:0, p:8'h00, exp_ra:8'h20, exp_cnt:2};
    tbl[5] = '{v:1, c:0, r:1, clr:0, p:8'h00, exp_ra:8'h10, exp_cnt:1};
    tbl[6] = '{v:0, c:1, r:1, clr:0, p:8'hEE, exp_ra:8'h00, exp_cnt:0};
    tbl[7] = '{v:0, c:0, r:0, clr:0, p:8'h00, exp_ra:8'h00, exp_cnt:0};

    rst = 1'b1;
    drive(0, 0, 0, 8'h00, 0);
    @(posedge clk); #1;

    // 1: reset then idle
    do_reset();
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_ret_addr", int'(ret_addr), 0);
    chk("rst_flags", int'({ovf_err, unf_err, ret_taken}), 0);
    #1;

    // 2: three calls then three returns, from the vector table
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].r, tbl[i].p, tbl[i].clr);
      #1;
      chk($sformatf("tbl%0d_ret_addr", i), int'(ret_addr), int'(tbl[i].exp_ra));
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].exp_cnt);
      tick();
      #0;
      if (i >= 3 && i <= 5) chk($sformatf("tbl%0d_ret_taken", i), int'(ret_taken), 1);
    end

    // 3: overflow with 17 calls, then 16 returns
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      drive(1, 1, 0, 8'(i), 0);
      tick();
      if (i == 16) chk("ovf_full16", int'(full), 1);
      if (i == 16) chk("ovf_noerr16", int'(ovf_err), 0);
    end
    chk("ovf_err17", int'(ovf_err), 1);
    chk("ovf_count17", int'(count), 16);
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 1, 8'h00, 0);
      #1;
      chk($sformatf("ovf_ret%0d", i), int'(ret_addr), 17 - i);
      tick();
    end
    chk("ovf_drained", int'(empty), 1);

    // 4: underflow, then clear
    do_reset();
    drive(1, 0, 1, 8'h00, 0);
    #1;
    chk("unf_ret_addr", int'(ret_addr), 0);
    tick();
    chk("unf_set", int'(unf_err), 1);
    chk("unf_count", int'(count), 0);
    drive(0, 0, 0, 8'h00, 1);
    tick();
    chk("unf_cleared", int'(unf_err), 0);
    // clear coinciding with a new underflow: set wins
    drive(1, 0, 1, 8'h00, 1);
    tick();
    chk("unf_set_wins", int'(unf_err), 1);

    // 5: swap on a two-deep stack
    do_reset();
    drive(1, 1, 0, 8'h33, 0); tick();
    drive(1, 1, 0, 8'h44, 0); tick();
    drive(1, 1, 1, 8'h55, 0);
    #1;
    chk("swap_old_top", int'(ret_addr), 8'h44);
    tick();
    chk("swap_count", int'(count), 2);
    chk("swap_rt", int'(ret_taken), 1);
    drive(1, 0, 1, 8'h00, 0);
    #1;
    chk("swap_new_top", int'(ret_addr), 8'h55);
    tick();
    // swap on empty acts as a push and flags underflow
    do_reset();
    drive(1, 1, 1, 8'h66, 0); tick();
    chk("swap_empty_cnt", int'(count), 1);
    chk("swap_empty_unf", int'(unf_err), 1);
    chk("swap_empty_top", int'(ret_addr), 8'h66);

    // 6: gated slot changes nothing; reset mid-sequence
    drive(0, 1, 1, 8'h77, 0); tick();
    chk("gated_count", int'(count), 1);
    chk("gated_top", int'(ret_addr), 8'h66);
    for (int i = 0; i < 4; i++) begin drive(1, 1, 0, 8'(8'h80 + i), 0); tick(); end
    chk("mid_count5", int'(count), 5);
    rst = 1'b1;
    drive(1, 1, 0, 8'h99, 0);
    tick();
    rst = 1'b0;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_empty", int'(empty), 1);

    // Random traffic against the queue model
    for (int n = 0; n < 1500; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      rst = (r == 0);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 40,
            8'($urandom), $urandom_range(0, 19) == 0);
      tick();
    end
    rst = 1'b0;
    drive(0, 0, 0, 8'h00, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
